// File: rtl/data_break_arbiter_if.sv
// rtl/data_break_arbiter_if.sv - requester and CPU break-path signals of data_break_arbiter
// master: the arbiter; slave: requesters plus the CPU state_machine side.
interface data_break_arbiter_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0]      req;
    logic [NREQ-1:0]      req_dir;
    logic [15*NREQ-1:0]   req_addr;
    logic [12*NREQ-1:0]   req_wdata;
    logic [4:0]           state;
    logic                 break_in_prog;
    logic [11:0]          mem_rdata;
    logic                 data_break;
    logic                 to_disk;
    logic [14:0]          brk_addr;
    logic [11:0]          brk_wdata;
    logic [NREQ-1:0]      grant;
    logic [NREQ-1:0]      ack;
    logic [NREQ-1:0]      nak;
    logic [11:0]          rdata;

    modport master (
        input  req, req_dir, req_addr, req_wdata, state, break_in_prog, mem_rdata,
        output data_break, to_disk, brk_addr, brk_wdata, grant, ack, nak, rdata
    );

    modport slave (
        output req, req_dir, req_addr, req_wdata, state, break_in_prog, mem_rdata,
        input  data_break, to_disk, brk_addr, brk_wdata, grant, ack, nak, rdata
    );
endinterface

// File: rtl/data_break_arbiter.sv
// rtl/data_break_arbiter.sv - arbitrates DMA data-break requests onto the CPU break path
// Define ROUND_ROBIN_EN for rotating priority; otherwise fixed priority, index 0 highest.
module data_break_arbiter #(
    parameter int         NREQ    = 4,
    parameter int         TIMEOUT = 1023,
    parameter logic [4:0] DB2     = 5'd14
) (
    input  logic                 clk,
    input  logic                 reset,
    data_break_arbiter_if.master bus
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_XFER = 2'd2;
    localparam logic [1:0] S_ACK  = 2'd3;

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT);

    logic [1:0]      fsm;
    logic [CW-1:0]   wait_cnt;
    logic [NREQ-1:0] eligible;
    logic [IW-1:0]   win_idx;
    logic            win_any;
    logic            timeout_hit;
    logic            xfer_done;

    // The requester that was just nak'd still holds req on the following edge.
    assign eligible    = bus.req & ~bus.nak;
    assign timeout_hit = (fsm == S_REQ) && !bus.break_in_prog && (wait_cnt == CNT_MAX);
    assign xfer_done   = (fsm == S_XFER) && !bus.break_in_prog;

`ifdef ROUND_ROBIN_EN
    logic [IW-1:0] ptr;
    logic [IW-1:0] gnt_idx;
    logic [IW-1:0] cand;

    function automatic logic [IW-1:0] next_ptr(input logic [IW-1:0] idx);
        return (int'(idx) == NREQ - 1) ? '0 : idx + 1'b1;
    endfunction

    // Scan downward so the candidate closest to the pointer is assigned last.
    always_comb begin
        win_idx = '0;
        win_any = 1'b0;
        cand    = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            cand = IW'((int'(ptr) + k) % NREQ);
            if (eligible[cand]) begin
                win_idx = cand;
                win_any = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr     <= '0;
            gnt_idx <= '0;
        end else begin
            if (fsm == S_IDLE && win_any) begin
                gnt_idx <= win_idx;
            end
            if (timeout_hit || xfer_done) begin
                ptr <= next_ptr(gnt_idx);
            end
        end
    end
`else
    always_comb begin
        win_idx = '0;
        win_any = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (eligible[k]) begin
                win_idx = IW'(k);
                win_any = 1'b1;
            end
        end
    end
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fsm            <= S_IDLE;
            wait_cnt       <= '0;
            bus.data_break <= 1'b0;
            bus.to_disk    <= 1'b0;
            bus.brk_addr   <= '0;
            bus.brk_wdata  <= '0;
            bus.grant      <= '0;
            bus.ack        <= '0;
            bus.nak        <= '0;
            bus.rdata      <= '0;
        end else begin
            bus.ack <= '0;
            bus.nak <= '0;
            case (fsm)
                S_IDLE: begin
                    if (win_any) begin
                        bus.grant      <= NREQ'(1) << win_idx;
                        bus.to_disk    <= bus.req_dir[win_idx];
                        bus.brk_addr   <= bus.req_addr[int'(win_idx)*15 +: 15];
                        bus.brk_wdata  <= bus.req_wdata[int'(win_idx)*12 +: 12];
                        bus.data_break <= 1'b1;
                        wait_cnt       <= '0;
                        fsm            <= S_REQ;
                    end
                end
                S_REQ: begin
                    // A break taken on the expiry edge wins over the timeout.
                    if (bus.break_in_prog) begin
                        bus.data_break <= 1'b0;
                        fsm            <= S_XFER;
                    end else if (wait_cnt == CNT_MAX) begin
                        bus.data_break <= 1'b0;
                        bus.nak        <= bus.grant;
                        bus.grant      <= '0;
                        fsm            <= S_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                S_XFER: begin
                    if (bus.state == DB2 && bus.to_disk) begin
                        bus.rdata <= bus.mem_rdata;
                    end
                    if (!bus.break_in_prog) begin
                        bus.ack <= bus.grant;
                        fsm     <= S_ACK;
                    end
                end
                S_ACK: begin
                    bus.grant <= '0;
                    fsm       <= S_IDLE;
                end
                default: fsm <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_break_arbiter.sv
// tb/tb_data_break_arbiter.sv - self-checking bench for data_break_arbiter
module tb_data_break_arbiter;

    localparam int         NREQ    = 4;
    localparam int         TIMEOUT = 15;
    localparam logic [4:0] F0  = 5'd0;
    localparam logic [4:0] DB0 = 5'd12;
    localparam logic [4:0] DB1 = 5'd13;
    localparam logic [4:0] DB2 = 5'd14;
    localparam int M_IDLE = 0, M_WAIT = 1, M_BREAK = 2, M_DONE = 3;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    data_break_arbiter_if #(.NREQ(NREQ)) bus ();

    data_break_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT), .DB2(DB2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: owner index, phase and wait length tracked directly.
    int          m_phase, m_owner, m_waited, m_ptr, m_ack_to, m_nak_to;
    logic        m_db, m_dir;
    logic [14:0] m_addr;
    logic [11:0] m_wdata, m_rdata;

    int  rq_idle [NREQ];
    bit  rq_drop [NREQ];
    int  cpu_ph, cpu_cnt, cpu_n;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [NREQ-1:0] onehot(input int i);
        return (i < 0) ? '0 : NREQ'(1) << i;
    endfunction

    function automatic int pick(input logic [NREQ-1:0] r, input int excl);
        int start;
        int i;
`ifdef ROUND_ROBIN_EN
        start = m_ptr;
`else
        start = 0;
`endif
        for (int k = 0; k < NREQ; k++) begin
            i = (start + k) % NREQ;
            if (r[i] && i != excl) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_phase = M_IDLE; m_owner = -1; m_waited = 0; m_ptr = 0;
        m_ack_to = -1; m_nak_to = -1;
        m_db = 1'b0; m_dir = 1'b0; m_addr = '0; m_wdata = '0; m_rdata = '0;
    endtask

    task automatic model_step();
        int last_nak;
        int w;
        last_nak = m_nak_to;
        m_ack_to = -1;
        m_nak_to = -1;
        if (!reset) begin
            model_reset();
            return;
        end
        case (m_phase)
            M_IDLE: begin
                w = pick(bus.req, last_nak);
                if (w >= 0) begin
                    m_owner  = w;
                    m_db     = 1'b1;
                    m_dir    = bus.req_dir[w];
                    m_addr   = bus.req_addr[15*w +: 15];
                    m_wdata  = bus.req_wdata[12*w +: 12];
                    m_waited = 0;
                    m_phase  = M_WAIT;
                end
            end
            M_WAIT: begin
                if (bus.break_in_prog) begin
                    m_db = 1'b0;
                    m_phase = M_BREAK;
                end else if (m_waited == TIMEOUT) begin
                    m_db = 1'b0;
                    m_nak_to = m_owner;
                    m_ptr = (m_owner + 1) % NREQ;
                    m_owner = -1;
                    m_phase = M_IDLE;
                end else begin
                    m_waited++;
                end
            end
            M_BREAK: begin
                if (bus.state == DB2 && m_dir) m_rdata = bus.mem_rdata;
                if (!bus.break_in_prog) begin
                    m_ack_to = m_owner;
                    m_ptr = (m_owner + 1) % NREQ;
                    m_phase = M_DONE;
                end
            end
            default: begin
                m_owner = -1;
                m_phase = M_IDLE;
            end
        endcase
    endtask

    task automatic compare();
        chk("data_break", bus.data_break, m_db);
        chk("to_disk", bus.to_disk, m_dir);
        chk("brk_addr", bus.brk_addr, m_addr);
        chk("brk_wdata", bus.brk_wdata, m_wdata);
        chk("grant", bus.grant, onehot(m_owner));
        chk("ack", bus.ack, onehot(m_ack_to));
        chk("nak", bus.nak, onehot(m_nak_to));
        chk("rdata", bus.rdata, m_rdata);
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        compare();
    endtask

    task automatic serve(input logic [11:0] rd);
        int n;
        n = 0;
        while (!bus.data_break && n < 8) begin
            cycle();
            n++;
        end
        chk("serve_db_raised", bus.data_break, 1'b1);
        bus.break_in_prog = 1'b1; bus.state = DB0; cycle();
        chk("serve_db_dropped", bus.data_break, 1'b0);
        bus.state = DB1; cycle();
        bus.state = DB2; bus.mem_rdata = rd; cycle();
        bus.break_in_prog = 1'b0; bus.state = F0; cycle();
    endtask

    function automatic int choose_wait();
        int r;
        r = $urandom_range(0, 9);
        if (r < 6)  return $urandom_range(0, 5);
        if (r == 6) return TIMEOUT;
        if (r == 7) return TIMEOUT - 1;
        if (r == 8) return TIMEOUT + 1 + $urandom_range(0, 3);
        return $urandom_range(6, 12);
    endfunction

    task automatic env_step();
        for (int i = 0; i < NREQ; i++) begin
            if (rq_drop[i]) begin
                bus.req[i] = 1'b0;
                rq_drop[i] = 1'b0;
                rq_idle[i] = $urandom_range(0, 6);
            end else if (bus.req[i] && (bus.ack[i] || bus.nak[i])) begin
                rq_drop[i] = 1'b1;
            end else if (!bus.req[i]) begin
                if (rq_idle[i] > 0) begin
                    rq_idle[i]--;
                end else if ($urandom_range(0, 3) == 0) begin
                    bus.req[i] = 1'b1;
                    bus.req_dir[i] = 1'($urandom);
                    bus.req_addr[15*i +: 15] = 15'($urandom);
                    bus.req_wdata[12*i +: 12] = 12'($urandom);
                end
            end
        end
        bus.mem_rdata = 12'($urandom);
        if (cpu_ph == 0 && bus.data_break) begin
            cpu_cnt = choose_wait();
            cpu_ph = 1;
        end
        if (cpu_ph == 1) begin
            if (!bus.data_break) begin
                cpu_ph = 0;
            end else if (cpu_cnt == 0) begin
                bus.break_in_prog = 1'b1;
                bus.state = DB0;
                cpu_n = 0;
                cpu_ph = 2;
            end else begin
                cpu_cnt--;
            end
        end else if (cpu_ph == 2) begin
            cpu_n++;
            if (cpu_n == 1) begin
                bus.state = DB1;
            end else if (cpu_n == 2) begin
                bus.state = DB2;
            end else begin
                bus.break_in_prog = 1'b0;
                cpu_ph = 0;
            end
        end else begin
            bus.state = 5'($urandom_range(0, 11));
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int exp_order [4];
`ifdef ROUND_ROBIN_EN
        exp_order = '{1, 3, 1, 3};
`else
        exp_order = '{1, 1, 1, 1};
`endif
        bus.req = '0; bus.req_dir = '0; bus.req_addr = '0; bus.req_wdata = '0;
        bus.state = F0; bus.break_in_prog = 1'b0; bus.mem_rdata = '0;
        model_reset();
        cycle();
        cycle();
        chk("rst_data_break", bus.data_break, 1'b0);
        chk("rst_grant", bus.grant, 4'b0000);
        chk("rst_rdata", bus.rdata, 12'o0000);
        reset = 1'b1;
        cycle();

        // Single request, device to memory
        bus.req = 4'b0010;
        bus.req_addr[15 +: 15] = 15'o07000;
        bus.req_wdata[12 +: 12] = 12'o1234;
        cycle();
        chk("A_data_break", bus.data_break, 1'b1);
        chk("A_grant", bus.grant, 4'b0010);
        chk("A_brk_addr", bus.brk_addr, 15'o07000);
        chk("A_brk_wdata", bus.brk_wdata, 12'o1234);
        serve(12'o7777);
        chk("A_ack", bus.ack, 4'b0010);
        chk("A_rdata_kept", bus.rdata, 12'o0000);
        cycle();
        chk("A_ack_once", bus.ack, 4'b0000);
        bus.req = '0;
        cycle();

        // Read capture, memory to device
        bus.req = 4'b0001; bus.req_dir = 4'b0001;
        bus.req_addr[0 +: 15] = 15'($urandom);
        cycle();
        chk("B_to_disk", bus.to_disk, 1'b1);
        serve(12'o4321);
        chk("B_ack", bus.ack, 4'b0001);
        chk("B_rdata", bus.rdata, 12'o4321);
        chk("B_to_disk_ack", bus.to_disk, 1'b1);
        cycle();
        bus.req = '0;
        cycle();

        // Timeout with the CPU never taking the break
        bus.req = 4'b0100; bus.req_dir = 4'b0100;
        cycle();
        for (int k = 1; k <= TIMEOUT; k++) cycle();
        chk("C_nak_early", bus.nak, 4'b0000);
        chk("C_db_waiting", bus.data_break, 1'b1);
        cycle();
        chk("C_nak", bus.nak, 4'b0100);
        chk("C_db_low", bus.data_break, 1'b0);
        chk("C_no_ack", bus.ack, 4'b0000);
        chk("C_grant_clear", bus.grant, 4'b0000);
        cycle();
        chk("C_no_regrant", bus.data_break, 1'b0);
        bus.req = '0;
        cycle();

        // Break arrives on the expiry edge
        bus.req = 4'b0100;
        cycle();
        for (int k = 1; k <= TIMEOUT; k++) cycle();
        bus.break_in_prog = 1'b1; bus.state = DB0;
        cycle();
        chk("D_no_nak", bus.nak, 4'b0000);
        chk("D_db_low", bus.data_break, 1'b0);
        chk("D_grant", bus.grant, 4'b0100);
        bus.state = DB1; cycle();
        bus.state = DB2; bus.mem_rdata = 12'o0707; cycle();
        bus.break_in_prog = 1'b0; bus.state = F0; cycle();
        chk("D_ack", bus.ack, 4'b0100);
        chk("D_rdata", bus.rdata, 12'o0707);
        cycle();
        bus.req = '0; bus.req_dir = '0;
        cycle();

        // Asynchronous reset in the middle of a transfer
        bus.req = 4'b0001;
        cycle();
        bus.break_in_prog = 1'b1; bus.state = DB0; cycle();
        bus.state = DB1; cycle();
        bus.req = '0;
        #2 reset = 1'b0;
        #1;
        model_reset();
        chk("F_db", bus.data_break, 1'b0);
        chk("F_grant", bus.grant, 4'b0000);
        compare();
        cycle();
        bus.break_in_prog = 1'b0; bus.state = F0; reset = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cycle();
            chk("F_no_ack", bus.ack, 4'b0000);
        end

        // Contention with two requesters held high
        bus.req = 4'b1010;
        for (int g = 0; g < 4; g++) begin
            serve(12'($urandom));
            chk("E_order", bus.ack, onehot(exp_order[g]));
            cycle();
        end
        bus.req = '0;
        cycle();
        cycle();

        // Randomized traffic
        for (int i = 0; i < NREQ; i++) begin
            rq_idle[i] = 0;
            rq_drop[i] = 1'b0;
        end
        cpu_ph = 0; cpu_cnt = 0; cpu_n = 0;
        for (int c = 0; c < 4000; c++) begin
            env_step();
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
